// File: rtl/cla_sub_serial.sv
// rtl/cla_sub_serial.sv - digit-serial subtractor, one 4-bit CLA slice per clock
module cla_sub_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;
  logic [3:0] w_d;
  logic       w_cout;
  logic       w_ovf;

  // Select the current nibble of the latched operands; subtrahend is inverted.
  always_comb begin
    w_x = 4'd0;
    w_y = 4'd0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_x = r_a[4*k +: 4];
        w_y = ~r_b[4*k +: 4];
      end
    end
  end

  // 4-bit carry-lookahead: every carry is a flat sum of generate/propagate terms.
  always_comb begin
    w_p    = w_x ^ w_y;
    w_g    = w_x & w_y;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & r_carry);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_d    = w_p ^ w_c;
    // Signed overflow: operands differ in sign and result sign differs from a.
    w_ovf  = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d[3] ^ r_a[WIDTH-1]);
  end

  // Control FSM with registered handshakes; one slice is retired per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_borrow    <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            // Subtract as a + ~b + 1; an incoming borrow removes the +1.
            r_carry    <= ~bin;
            r_cnt      <= '0;
            r_diff     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (r_cnt == CNT_W'(k)) begin
              r_diff[4*k +: 4] <= w_d;
            end
          end
          r_carry <= w_cout;
          if (r_cnt == LAST_CNT) begin
            r_borrow    <= ~w_cout;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;

endmodule
